// File: rtl/dac_ctrl_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dac_ctrl_gen
//  Description : Parallel DAC driver. Signed sample to offset-binary code with
//                rounding/saturation, plus DAC reset/lock/sleep sequencing.
//  Revision    : 1.0  initial release
// ============================================================================
module dac_ctrl_gen #(
    parameter int DIN_W     = 16,
    parameter int DAC_W     = 14,
    parameter int RST_PULSE = 16,
    parameter bit ROUND_DEF = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIN_W-1:0] data_in,
    input  logic             en,
    input  logic             pll_lock,
    input  logic [7:0]       upr,
    input  logic             en_upr,
    output logic [DAC_W-1:0] dac_d,
    output logic [15:0]      data_o,
    output logic [1:0]       div,
    output logic [1:0]       mod,
    output logic             sleep,
    output logic             dac_rst,
    output logic [1:0]       state_o
);

    localparam logic [1:0] c_S_RESET = 2'd0;
    localparam logic [1:0] c_S_WAIT  = 2'd1;
    localparam logic [1:0] c_S_RUN   = 2'd2;
    localparam logic [1:0] c_S_SLEEP = 2'd3;

    localparam logic [DAC_W-1:0]   c_MID      = {1'b1, {(DAC_W-1){1'b0}}};
    localparam int                 c_CNT_W    = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(RST_PULSE - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_rst_cnt;
    logic [1:0]         r_div;
    logic [1:0]         r_mod;
    logic               r_sleep_req;
    logic               r_round_en;
    logic               r_inv;
    logic [DAC_W-1:0]   r_s1;
    logic [DAC_W-1:0]   r_dac;

    logic               w_soft_rst;
    logic               w_run;
    logic [DIN_W-1:0]   w_off;
    logic [DAC_W-1:0]   w_code_raw;
    logic [DAC_W-1:0]   w_code;

    assign w_soft_rst = en_upr & upr[5];
    assign w_run      = (r_state == c_S_RUN);

    // Control register; the soft-reset bit acts directly on the FSM and is not stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= 2'd0;
            r_mod       <= 2'd0;
            r_sleep_req <= 1'b0;
            r_round_en  <= ROUND_DEF;
            r_inv       <= 1'b0;
        end else if (en_upr) begin
            r_div       <= upr[1:0];
            r_mod       <= upr[3:2];
            r_sleep_req <= upr[4];
            r_round_en  <= upr[6];
            r_inv       <= upr[7];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_RESET;
            r_rst_cnt <= c_CNT_LOAD;
        end else if (w_soft_rst) begin
            r_state   <= c_S_RESET;
            r_rst_cnt <= c_CNT_LOAD;
        end else begin
            case (r_state)
                c_S_RESET: begin
                    if (r_rst_cnt == '0) begin
                        r_state <= c_S_WAIT;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - 1'b1;
                    end
                end
                c_S_WAIT: begin
                    if (r_sleep_req) begin
                        r_state <= c_S_SLEEP;
                    end else if (pll_lock) begin
                        r_state <= c_S_RUN;
                    end
                end
                c_S_RUN: begin
                    if (r_sleep_req) begin
                        r_state <= c_S_SLEEP;
                    end else if (!pll_lock) begin
                        r_state <= c_S_WAIT;
                    end
                end
                default: begin
                    if (!r_sleep_req) begin
                        r_state <= c_S_WAIT;
                    end
                end
            endcase
        end
    end

    // Offset binary is two's complement with the sign bit flipped.
    assign w_off = {~data_in[DIN_W-1], data_in[DIN_W-2:0]};

    generate
        if (DIN_W > DAC_W) begin : g_round
            localparam int             c_SH   = DIN_W - DAC_W;
            localparam logic [DIN_W:0] c_HALF = {{DIN_W{1'b0}}, 1'b1} << (c_SH - 1);
            logic [DIN_W:0]   w_sum;
            logic [DAC_W-1:0] w_rnd;
            logic             w_unused_lsb;

            assign w_sum        = {1'b0, w_off} + c_HALF;
            assign w_rnd        = w_sum[DIN_W] ? {DAC_W{1'b1}} : w_sum[DIN_W-1:c_SH];
            assign w_code_raw   = r_round_en ? w_rnd : w_off[DIN_W-1:c_SH];
            assign w_unused_lsb = ^w_sum[c_SH-1:0];
        end else begin : g_direct
            logic w_unused_round;
            assign w_code_raw     = w_off;
            assign w_unused_round = r_round_en;
        end
    endgenerate

    assign w_code = r_inv ? ~w_code_raw : w_code_raw;

    // Stage 2 is also gated by the current state so nothing stale escapes after leaving RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= c_MID;
            r_dac <= c_MID;
        end else begin
            r_s1  <= (w_run && en) ? w_code : c_MID;
            r_dac <= w_run ? r_s1 : c_MID;
        end
    end

    assign dac_d   = r_dac;
    assign data_o  = 16'(r_dac);
    assign div     = r_div;
    assign mod     = r_mod;
    assign sleep   = (r_state == c_S_SLEEP);
    assign dac_rst = (r_state == c_S_RESET);
    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dac_ctrl_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_ctrl_gen
//  Description : Self-checking bench for dac_ctrl_gen (default parameters).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dac_ctrl_gen;

    localparam logic [13:0] c_MID = 14'h2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic        en = 1'b0;
    logic        pll_lock = 1'b0;
    logic [7:0]  upr = 8'h0;
    logic        en_upr = 1'b0;
    logic [13:0] dac_d;
    logic [15:0] data_o;
    logic [1:0]  div;
    logic [1:0]  mod;
    logic        sleep;
    logic        dac_rst;
    logic [1:0]  state_o;

    int errors = 0;
    int checks = 0;

    dac_ctrl_gen dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .en       (en),
        .pll_lock (pll_lock),
        .upr      (upr),
        .en_upr   (en_upr),
        .dac_d    (dac_d),
        .data_o   (data_o),
        .div      (div),
        .mod      (mod),
        .sleep    (sleep),
        .dac_rst  (dac_rst),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] v);
        upr    = v;
        en_upr = 1'b1;
        tick();
        en_upr = 1'b0;
    endtask

    // Reference conversion using plain integer arithmetic on the sample value.
    function automatic logic [13:0] conv(input logic [15:0] d, input bit rnd, input bit inv);
        int off;
        int v;
        off = int'($signed(d)) + 32768;
        v   = rnd ? (off + 2) / 4 : off / 4;
        if (v > 16383) v = 16383;
        if (inv) v = 16383 - v;
        return v[13:0];
    endfunction

    task automatic test_reset();
        int bad;
        rst = 1'b1; pll_lock = 1'b1; en = 1'b0; en_upr = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (state_o !== 2'd0 || dac_rst !== 1'b1 || dac_d !== c_MID || data_o !== 16'h2000 ||
            div !== 2'd0 || mod !== 2'd0 || sleep !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: state=%0d dac_rst=%b dac_d=%h data_o=%h div=%0d mod=%0d sleep=%b, required 0 1 2000 2000 0 0 0",
                     state_o, dac_rst, dac_d, data_o, div, mod, sleep);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (dac_rst !== 1'b1 || state_o !== 2'd0 || dac_d !== c_MID) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_pulse: %0d of 16 cycles wrong, required 0", bad);
        end
        checks++;
        if (state_o !== 2'd1 || dac_rst !== 1'b0 || dac_d !== c_MID) begin
            errors++;
            $display("FAIL reset_end: state=%0d dac_rst=%b dac_d=%h, required 1 0 2000", state_o, dac_rst, dac_d);
        end
        tick();
        checks++;
        if (state_o !== 2'd2 || dac_d !== c_MID) begin
            errors++;
            $display("FAIL reset_to_run: state=%0d dac_d=%h, required 2 2000", state_o, dac_d);
        end
    endtask

    task automatic test_conversion();
        logic [15:0] din [4];
        logic [13:0] exp [4];
        din = '{16'h0000, 16'h7FFF, 16'h8000, 16'h0002};
        exp = '{14'h2000, 14'h3FFF, 14'h0000, 14'h2001};
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data_in = (k < 4) ? din[k] : 16'h0000;
            tick();
            checks++;
            if (k == 0) begin
                if (dac_d !== c_MID) begin
                    errors++;
                    $display("FAIL conv_latency: dac_d=%h one cycle after first input, required 2000", dac_d);
                end
            end else if (k <= 4) begin
                if (dac_d !== exp[k-1]) begin
                    errors++;
                    $display("FAIL conv_%0d: dac_d=%h, required %h", k - 1, dac_d, exp[k-1]);
                end
            end else if (dac_d !== 14'h2000) begin
                errors++;
                $display("FAIL conv_tail: dac_d=%h, required 2000", dac_d);
            end
        end
    endtask

    task automatic test_trunc_inv();
        wr(8'h00);
        data_in = 16'h0002; tick();
        data_in = 16'h0000; tick();
        checks++;
        if (dac_d !== 14'h2000) begin
            errors++;
            $display("FAIL trunc: dac_d=%h, required 2000", dac_d);
        end
        wr(8'h80);
        data_in = 16'h0000; tick();
        data_in = 16'h7FFF; tick();
        checks++;
        if (dac_d !== 14'h1FFF) begin
            errors++;
            $display("FAIL inv_zero: dac_d=%h, required 1fff", dac_d);
        end
        tick();
        checks++;
        if (dac_d !== 14'h0000) begin
            errors++;
            $display("FAIL inv_max: dac_d=%h, required 0000", dac_d);
        end
    endtask

    task automatic test_control_pins();
        data_in = 16'h4000;
        wr(8'h00);
        tick(); tick();
        wr(8'h4F);
        checks++;
        if (div !== 2'd3 || mod !== 2'd3 || dac_d !== 14'h3000) begin
            errors++;
            $display("FAIL ctrl_pins: div=%0d mod=%0d dac_d=%h, required 3 3 3000", div, mod, dac_d);
        end
        tick();
        checks++;
        if (dac_d !== 14'h3000) begin
            errors++;
            $display("FAIL ctrl_no_glitch: dac_d=%h, required 3000", dac_d);
        end
        wr(8'h10);
        tick();
        checks++;
        if (state_o !== 2'd3 || sleep !== 1'b1) begin
            errors++;
            $display("FAIL sleep_enter: state=%0d sleep=%b, required 3 1", state_o, sleep);
        end
        tick();
        checks++;
        if (dac_d !== c_MID || state_o !== 2'd3) begin
            errors++;
            $display("FAIL sleep_mid: dac_d=%h state=%0d, required 2000 3", dac_d, state_o);
        end
        wr(8'h00);
        tick();
        checks++;
        if (state_o !== 2'd1 || sleep !== 1'b0) begin
            errors++;
            $display("FAIL sleep_exit: state=%0d sleep=%b, required 1 0", state_o, sleep);
        end
        tick();
        checks++;
        if (state_o !== 2'd2) begin
            errors++;
            $display("FAIL sleep_to_run: state=%0d, required 2", state_o);
        end
    endtask

    task automatic test_pll_loss_en();
        data_in = 16'h4000; en = 1'b1;
        tick(); tick();
        checks++;
        if (dac_d !== 14'h3000) begin
            errors++;
            $display("FAIL pll_pre: dac_d=%h, required 3000", dac_d);
        end
        pll_lock = 1'b0;
        tick();
        checks++;
        if (state_o !== 2'd1) begin
            errors++;
            $display("FAIL pll_loss_state: state=%0d, required 1", state_o);
        end
        tick();
        checks++;
        if (dac_d !== c_MID) begin
            errors++;
            $display("FAIL pll_loss_mid: dac_d=%h, required 2000", dac_d);
        end
        pll_lock = 1'b1;
        tick();
        checks++;
        if (state_o !== 2'd2 || dac_d !== c_MID) begin
            errors++;
            $display("FAIL relock_first: state=%0d dac_d=%h, required 2 2000", state_o, dac_d);
        end
        tick();
        checks++;
        if (dac_d !== c_MID) begin
            errors++;
            $display("FAIL relock_second: dac_d=%h, required 2000", dac_d);
        end
        tick();
        checks++;
        if (dac_d !== 14'h3000) begin
            errors++;
            $display("FAIL relock_resume: dac_d=%h, required 3000", dac_d);
        end
        en = 1'b0;
        tick();
        checks++;
        if (dac_d !== 14'h3000) begin
            errors++;
            $display("FAIL en_low_pipe: dac_d=%h, required 3000", dac_d);
        end
        tick();
        checks++;
        if (dac_d !== c_MID) begin
            errors++;
            $display("FAIL en_low_mid: dac_d=%h, required 2000", dac_d);
        end
    endtask

    // Counts consecutive dac_rst-high samples; optionally re-issues a soft reset at sample 8.
    task automatic pulse_len(input bit inject, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (dac_rst !== 1'b1) break;
            n++;
            if (inject && n == 8) begin
                upr = 8'h20; en_upr = 1'b1;
            end else begin
                en_upr = 1'b0;
            end
            tick();
        end
        en_upr = 1'b0;
    endtask

    task automatic test_soft_reset();
        int n;
        wr(8'h10);
        tick();
        wr(8'h30);
        checks++;
        if (state_o !== 2'd0 || dac_rst !== 1'b1) begin
            errors++;
            $display("FAIL soft_in_sleep: state=%0d dac_rst=%b, required 0 1", state_o, dac_rst);
        end
        pulse_len(1'b0, n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL soft_pulse_len: %0d cycles, required 16", n);
        end
        tick();
        checks++;
        if (state_o !== 2'd3) begin
            errors++;
            $display("FAIL soft_sleep_kept: state=%0d, required 3", state_o);
        end
        wr(8'h00);
        tick(); tick();
        wr(8'h20);
        pulse_len(1'b1, n);
        checks++;
        if (n != 24) begin
            errors++;
            $display("FAIL soft_restart_len: %0d cycles, required 24", n);
        end
    endtask

    task automatic test_random_stream();
        logic [13:0] s1;
        logic [13:0] nxt;
        bit          m_round;
        bit          m_inv;
        logic [1:0]  m_div;
        logic [1:0]  m_mod;
        int          n;
        n = 0;
        while (state_o !== 2'd2 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (state_o !== 2'd2) begin
            errors++;
            $display("FAIL rand_wait_run: state=%0d, required 2", state_o);
        end
        m_round = 1'b0; m_inv = 1'b0; m_div = 2'd0; m_mod = 2'd0;
        en = 1'b0;
        tick(); tick();
        s1 = c_MID;
        for (int i = 0; i < 300; i++) begin
            data_in = 16'($urandom);
            en      = ($urandom_range(0, 3) != 0);
            en_upr  = ($urandom_range(0, 7) == 0);
            upr     = 8'($urandom) & 8'hCF;
            nxt = en ? conv(data_in, m_round, m_inv) : c_MID;
            tick();
            if (en_upr) begin
                m_div   = upr[1:0];
                m_mod   = upr[3:2];
                m_round = upr[6];
                m_inv   = upr[7];
            end
            en_upr = 1'b0;
            checks++;
            if (dac_d !== s1 || data_o !== {2'b00, s1} || div !== m_div || mod !== m_mod) begin
                errors++;
                $display("FAIL rand_%0d: dac_d=%h data_o=%h div=%0d mod=%0d, required %h %h %0d %0d",
                         i, dac_d, data_o, div, mod, s1, {2'b00, s1}, m_div, m_mod);
            end
            s1 = nxt;
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_trunc_inv();
        test_control_pins();
        test_pll_loss_en();
        test_soft_reset();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
